// File: rtl/text_console_ctrl.sv
// Character RAM owner for the OLED text path: display lookups take priority, a
// terminal-style host writer (cursor, LF, CR, BS, FF-clear) uses the spare cycles.
module text_console_ctrl #(
  parameter int         COLS  = 16,
  parameter int         ROWS  = 8,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_read,
  input  logic [2:0]              d_page_idx,
  input  logic [6:0]              d_column_idx,
  output logic [7:0]              t_char,
  output logic                    t_valid,
  input  logic                    h_valid,
  input  logic [7:0]              h_char,
  output logic                    h_ready,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int DEPTH = ROWS * COLS;

  typedef enum logic [0:0] {ST_CLEAR, ST_IDLE} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_clr_addr;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_t_char;
  logic            r_t_valid;
  logic [7:0]      r_mem [DEPTH];

  state_t          w_state_next;
  logic [AW-1:0]   w_clr_addr_next;
  logic [CW-1:0]   w_col_next;
  logic [RW-1:0]   w_row_next;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [7:0]      w_wdata;
  logic [AW-1:0]   w_raddr;
  logic            w_accept;

  // Each character cell spans 8 pixel columns, so the cell index is column/8.
  assign w_raddr  = {d_page_idx[RW-1:0], d_column_idx[3 +: CW]};
  assign h_ready  = (r_state == ST_IDLE) && !d_read;
  assign w_accept = h_valid && h_ready;
  assign busy     = (r_state == ST_CLEAR);

  assign t_char     = r_t_char;
  assign t_valid    = r_t_valid;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_char  <= 8'h00;
      r_t_valid <= 1'b0;
    end else begin
      r_t_valid <= d_read;
      if (d_read) r_t_char <= r_mem[w_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
      r_col      <= w_col_next;
      r_row      <= w_row_next;
    end
  end

  // Writes only ever happen in cycles without d_read, so the RAM sees one access per cycle.
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_col_next      = r_col;
    w_row_next      = r_row;
    w_we            = 1'b0;
    w_waddr         = r_clr_addr;
    w_wdata         = BLANK;
    case (r_state)
      ST_CLEAR: begin
        if (!d_read) begin
          w_we = 1'b1;
          if (r_clr_addr == AW'(DEPTH - 1)) begin
            w_state_next    = ST_IDLE;
            w_clr_addr_next = '0;
            w_col_next      = '0;
            w_row_next      = '0;
          end else begin
            w_clr_addr_next = r_clr_addr + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (h_char >= 8'h20 && h_char <= 8'h7E) begin
            w_we       = 1'b1;
            w_waddr    = {r_row, r_col};
            w_wdata    = h_char;
            // Power-of-two geometry: column and row wrap by natural overflow.
            w_col_next = r_col + 1'b1;
            if (r_col == CW'(COLS - 1)) w_row_next = r_row + 1'b1;
          end else begin
            case (h_char)
              8'h0A: begin
                w_col_next = '0;
                w_row_next = r_row + 1'b1;
              end
              8'h0D: w_col_next = '0;
              8'h08: if (r_col != '0) w_col_next = r_col - 1'b1;
              8'h0C: begin
                w_state_next    = ST_CLEAR;
                w_clr_addr_next = '0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

endmodule
